// File: rtl/ballot_if.sv
// Voter-side signal bundle of the ballot unit: officer/voter inputs and vote outputs.
interface ballot_if;
    logic       ballot_en;
    logic       btn1;
    logic       btn2;
    logic       btn3;
    logic       end_voting;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       ready;
    logic       closed;
    logic       timeout;
    logic [7:0] ballot_count;

    modport master (
        output ballot_en, btn1, btn2, btn3, end_voting,
        input  c1, c2, c3, ready, closed, timeout, ballot_count
    );

    modport slave (
        input  ballot_en, btn1, btn2, btn3, end_voting,
        output c1, c2, c3, ready, closed, timeout, ballot_count
    );
endinterface

// File: rtl/ballot_unit.sv
// Single-ballot voting unit: issues a ballot, debounces one candidate button,
// emits one vote pulse, cancels unused ballots on timeout and locks when the poll closes.
module ballot_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic    clk,
    input  logic    rst_n,
    ballot_if.slave bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARMED    = 3'd1;
    localparam logic [2:0] DEBOUNCE = 3'd2;
    localparam logic [2:0] CAST     = 3'd3;
    localparam logic [2:0] RELEASE  = 3'd4;
    localparam logic [2:0] CLOSED   = 3'd5;

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] TMO      = 8'(TIMEOUT_CYCLES);

    logic [2:0] state, state_n;
    logic [2:0] cand, cand_n;
    logic [3:0] dcnt, dcnt_n;
    logic [7:0] timer, timer_n;
    logic [2:0] votes, votes_n;
    logic       ready_r, ready_n;
    logic       closed_r, closed_n;
    logic       timeout_r, timeout_n;
    logic [7:0] count, count_n;

    logic [2:0] btns;
    logic       one_hot;
    logic [7:0] timer_inc;
    logic       expired;

    assign btns      = {bus.btn3, bus.btn2, bus.btn1};
    assign one_hot   = (btns == 3'b001) || (btns == 3'b010) || (btns == 3'b100);
    assign timer_inc = timer + 8'd1;
    assign expired   = (timer_inc == TMO);

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        dcnt_n    = dcnt;
        timer_n   = timer;
        votes_n   = '0;
        ready_n   = ready_r;
        closed_n  = closed_r;
        timeout_n = 1'b0;
        count_n   = count;

        case (state)
            IDLE: begin
                if (bus.end_voting) begin
                    state_n  = CLOSED;
                    closed_n = 1'b1;
                    ready_n  = 1'b0;
                end else if (bus.ballot_en && (btns == 3'b000)) begin
                    state_n = ARMED;
                    ready_n = 1'b1;
                    timer_n = '0;
                    dcnt_n  = '0;
                end
            end

            ARMED: begin
                if (bus.end_voting) begin
                    state_n  = CLOSED;
                    closed_n = 1'b1;
                    ready_n  = 1'b0;
                end else begin
                    timer_n = timer_inc;
                    // The edge leaving ARMED is the first debounce sample; with a
                    // one-cycle debounce it already qualifies the vote.
                    if (one_hot && (DEBOUNCE_CYCLES == 1)) begin
                        state_n = CAST;
                        cand_n  = btns;
                    end else if (expired) begin
                        state_n   = IDLE;
                        timeout_n = 1'b1;
                        ready_n   = 1'b0;
                    end else if (one_hot) begin
                        state_n = DEBOUNCE;
                        cand_n  = btns;
                        dcnt_n  = 4'd1;
                    end
                end
            end

            DEBOUNCE: begin
                if (bus.end_voting) begin
                    state_n  = CLOSED;
                    closed_n = 1'b1;
                    ready_n  = 1'b0;
                end else begin
                    timer_n = timer_inc;
                    // Qualification is tested before expiry so a vote completing
                    // on the expiry edge still counts.
                    if ((btns == cand) && (dcnt == DEB_LAST)) begin
                        state_n = CAST;
                    end else if (expired) begin
                        state_n   = IDLE;
                        timeout_n = 1'b1;
                        ready_n   = 1'b0;
                    end else if (btns == cand) begin
                        dcnt_n = dcnt + 4'd1;
                    end else begin
                        state_n = ARMED;
                        dcnt_n  = '0;
                        timer_n = '0;
                    end
                end
            end

            CAST: begin
                votes_n = cand;
                ready_n = 1'b0;
                count_n = (count == 8'hFF) ? count : count + 8'd1;
                // closed is held off one cycle so the final pulse never overlaps it.
                state_n = bus.end_voting ? CLOSED : RELEASE;
            end

            RELEASE: begin
                if (bus.end_voting) begin
                    state_n  = CLOSED;
                    closed_n = 1'b1;
                end else if (btns == 3'b000) begin
                    state_n = IDLE;
                end
            end

            CLOSED: begin
                closed_n = 1'b1;
                ready_n  = 1'b0;
            end

            default: begin
                state_n = IDLE;
                ready_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            dcnt      <= '0;
            timer     <= '0;
            votes     <= '0;
            ready_r   <= 1'b0;
            closed_r  <= 1'b0;
            timeout_r <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            dcnt      <= dcnt_n;
            timer     <= timer_n;
            votes     <= votes_n;
            ready_r   <= ready_n;
            closed_r  <= closed_n;
            timeout_r <= timeout_n;
            count     <= count_n;
        end
    end

    assign bus.c1           = votes[0];
    assign bus.c2           = votes[1];
    assign bus.c3           = votes[2];
    assign bus.ready        = ready_r;
    assign bus.closed       = closed_r;
    assign bus.timeout      = timeout_r;
    assign bus.ballot_count = count;

endmodule

// File: tb/tb_ballot_unit.sv
// Directed bench for ballot_unit: cycle-by-cycle vector table plus hand-written
// sequences for timeout, vote/expiry race, multi-ballot tallies and saturation.
module tb_ballot_unit;

    logic clk = 1'b0;
    logic rst_n;

    ballot_if bus ();

    ballot_unit #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int n_c1 = 0, n_c2 = 0, n_c3 = 0, n_to = 0, n_multi = 0;

    always @(negedge clk) begin
        if (bus.c1) n_c1++;
        if (bus.c2) n_c2++;
        if (bus.c3) n_c3++;
        if (bus.timeout) n_to++;
        if ((int'(bus.c1) + int'(bus.c2) + int'(bus.c3)) > 1) n_multi++;
    end

    typedef struct {
        bit       rst_n;
        bit       en;
        bit [2:0] btn;
        bit       ev;
        bit [2:0] c;
        bit       rdy;
        bit       cls;
        bit       to;
        bit [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit en, bit [2:0] b, bit ev,
                                bit [2:0] c, bit rdy, bit cls, bit to, bit [7:0] cnt);
        vec_t v;
        v.rst_n = r; v.en = en; v.btn = b; v.ev = ev;
        v.c = c; v.rdy = rdy; v.cls = cls; v.to = to; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    function automatic void add_n(int n, bit r, bit en, bit [2:0] b, bit ev,
                                  bit [2:0] c, bit rdy, bit cls, bit to, bit [7:0] cnt);
        for (int i = 0; i < n; i++) add(r, en, b, ev, c, rdy, cls, to, cnt);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input bit [2:0] b, input bit ev);
        bus.ballot_en  = en;
        bus.btn1       = b[0];
        bus.btn2       = b[1];
        bus.btn3       = b[2];
        bus.end_voting = ev;
    endtask

    task automatic do_reset();
        drive(0, 3'b000, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic vote(input bit [2:0] b);
        drive(1, 3'b000, 0);
        tick();
        drive(0, b, 0);
        repeat (4) tick();
        drive(0, 3'b000, 0);
        tick();
        tick();
    endtask

    function automatic int outs();
        return int'({bus.c3, bus.c2, bus.c1, bus.ready, bus.closed, bus.timeout, bus.ballot_count});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int base1, base2, base3, baseto;
        // Basic vote on btn2
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(4, 1, 0, 3'b010, 0, 3'b000, 1, 0, 0, 0);
        add  (1, 0, 3'b000, 0, 3'b010, 0, 0, 0, 1);
        add  (1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 1);
        // btn1 too short, then btn3
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(3, 1, 0, 3'b001, 0, 3'b000, 1, 0, 0, 0);
        add  (1, 0, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(4, 1, 0, 3'b100, 0, 3'b000, 1, 0, 0, 0);
        add  (1, 0, 3'b000, 0, 3'b100, 0, 0, 0, 1);
        add  (1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 1);
        // Two buttons overlap, then btn1 alone, held past the vote
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(10, 1, 0, 3'b101, 0, 3'b000, 1, 0, 0, 0);
        add_n(4, 1, 0, 3'b001, 0, 3'b000, 1, 0, 0, 0);
        add  (1, 0, 3'b001, 0, 3'b001, 0, 0, 0, 1);
        add_n(3, 1, 0, 3'b001, 0, 3'b000, 0, 0, 0, 1);
        add  (1, 1, 3'b001, 0, 3'b000, 0, 0, 0, 1);
        add  (1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 1);
        add  (1, 1, 3'b001, 0, 3'b000, 0, 0, 0, 1);
        add  (1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 1);
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 1);
        add_n(4, 1, 0, 3'b001, 0, 3'b000, 1, 0, 0, 1);
        add  (1, 0, 3'b000, 0, 3'b001, 0, 0, 0, 2);
        add  (1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 2);
        // Poll closed from IDLE
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 0, 3'b000, 1, 3'b000, 0, 1, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 0, 1, 0, 0);
        add_n(5, 1, 0, 3'b001, 0, 3'b000, 0, 1, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 0, 1, 0, 0);
        // end_voting during CAST: pulse completes, then closed
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(4, 1, 0, 3'b010, 0, 3'b000, 1, 0, 0, 0);
        add  (1, 0, 3'b000, 1, 3'b010, 0, 0, 0, 1);
        add  (1, 0, 3'b000, 0, 3'b000, 0, 1, 0, 1);
        add  (1, 1, 3'b010, 0, 3'b000, 0, 1, 0, 1);
        // end_voting during DEBOUNCE aborts the vote
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(2, 1, 0, 3'b100, 0, 3'b000, 1, 0, 0, 0);
        add  (1, 0, 3'b100, 1, 3'b000, 0, 1, 0, 0);
        add_n(3, 1, 0, 3'b100, 0, 3'b000, 0, 1, 0, 0);
        // Reset during DEBOUNCE
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(2, 1, 0, 3'b100, 0, 3'b000, 1, 0, 0, 0);
        add  (0, 0, 3'b100, 0, 3'b000, 0, 0, 0, 0);
        add_n(5, 1, 0, 3'b100, 0, 3'b000, 0, 0, 0, 0);
        // Reset during CAST
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 1, 3'b000, 0, 3'b000, 1, 0, 0, 0);
        add_n(4, 1, 0, 3'b010, 0, 3'b000, 1, 0, 0, 0);
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add_n(2, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        // ballot_en with a button already down is ignored
        add  (0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0);
        add  (1, 1, 3'b010, 0, 3'b000, 0, 0, 0, 0);
        add_n(5, 1, 0, 3'b010, 0, 3'b000, 0, 0, 0, 0);

        drive(0, 3'b000, 0);
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_state", outs(), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            drive(vecs[i].en, vecs[i].btn, vecs[i].ev);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  int'({vecs[i].c, vecs[i].rdy, vecs[i].cls, vecs[i].to, vecs[i].cnt}));
        end

        // Reset acts without a clock edge
        do_reset();
        drive(1, 3'b000, 0);
        tick();
        drive(0, 3'b010, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ready", int'(bus.ready), 0);
        rst_n = 1'b1;

        // Unused ballot times out after 255 cycles
        do_reset();
        baseto = n_to;
        base2  = n_c2;
        drive(1, 3'b000, 0);
        tick();
        check("to_armed_ready", int'(bus.ready), 1);
        drive(0, 3'b000, 0);
        bad = 0;
        repeat (254) begin
            tick();
            if (!bus.ready || bus.timeout) bad++;
        end
        check("to_wait_ready_held", bad, 0);
        tick();
        check("to_pulse", int'({bus.timeout, bus.ready}), 2);
        check("to_count_unchanged", int'(bus.ballot_count), 0);
        tick();
        check("to_pulse_one_cycle", int'(bus.timeout), 0);
        drive(0, 3'b010, 0);
        repeat (8) tick();
        check("to_no_late_vote", n_c2 - base2, 0);
        check("to_pulse_count", n_to - baseto, 1);
        drive(0, 3'b000, 0);
        tick();

        // Vote qualifying on the expiry edge wins
        do_reset();
        baseto = n_to;
        drive(1, 3'b000, 0);
        tick();
        drive(0, 3'b000, 0);
        repeat (251) tick();
        drive(0, 3'b010, 0);
        repeat (4) tick();
        check("race_no_timeout", int'({bus.timeout, bus.ready}), 1);
        drive(0, 3'b000, 0);
        tick();
        check("race_vote", int'({bus.c3, bus.c2, bus.c1, bus.ballot_count}), 'h201);
        tick();
        check("race_timeout_count", n_to - baseto, 0);

        // Eight ballots: 1,2,3,3,1,1,3,1
        do_reset();
        base1 = n_c1; base2 = n_c2; base3 = n_c3;
        vote(3'b001); vote(3'b010); vote(3'b100); vote(3'b100);
        vote(3'b001); vote(3'b001); vote(3'b100); vote(3'b001);
        check("tally_count", int'(bus.ballot_count), 8);
        check("tally_c1", n_c1 - base1, 4);
        check("tally_c2", n_c2 - base2, 1);
        check("tally_c3", n_c3 - base3, 3);

        // Counter saturates at 255
        do_reset();
        base2 = n_c2;
        repeat (260) vote(3'b010);
        check("sat_count", int'(bus.ballot_count), 255);
        check("sat_pulses", n_c2 - base2, 260);

        check("never_two_votes", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ballot_unit.md
BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 The module SHALL provide parameter DEBOUNCE_CYCLES, default 4 (range 1..15): consecutive sampled cycles a single button must be held before a vote is issued.
REQ-002 The module SHALL provide parameter TIMEOUT_CYCLES, default 255 (range 8..255): cycles an issued ballot may stay unused before it is cancelled.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port ballot_en  input  1  presiding-officer pulse that issues one ballot.
REQ-006 Port btn1, btn2, btn3  input  1 each  voter candidate buttons, synchronous to clk.
REQ-007 Port end_voting  input  1  closes the poll.
REQ-008 Port c1, c2, c3  output  1 each  one-cycle vote pulses to the counting machine.
REQ-009 Port ready  output  1  ballot issued, awaiting voter.
REQ-010 Port closed  output  1  poll closed, unit inert.
REQ-011 Port timeout  output  1  one-cycle pulse when an unused ballot is cancelled.
REQ-012 Port ballot_count  output  8  votes emitted since reset.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states SHALL be IDLE, ARMED, DEBOUNCE, CAST, RELEASE, CLOSED.
REQ-015 IDLE: ballot_en=1 with all buttons low SHALL go to ARMED, with ready=1 from the next cycle; ballot_en with any button high SHALL be ignored.
REQ-016 ballot_en outside IDLE SHALL be ignored, with no queueing.
REQ-017 ARMED: exactly one button sampled high SHALL go to DEBOUNCE and capture that candidate; zero or two or more buttons high SHALL keep ARMED.
REQ-018 DEBOUNCE: a vote SHALL be issued only if the captured button is sampled high and alone on DEBOUNCE_CYCLES consecutive edges, starting with the edge that left ARMED.
REQ-019 DEBOUNCE: any deviation (button released, changed, or a second button pressed) SHALL return to ARMED, and the debounce count SHALL restart.
REQ-020 CAST: exactly one of c1/c2/c3 SHALL be high for one cycle, at edge E0+DEBOUNCE_CYCLES, where E0 is the first qualifying edge.
REQ-021 In the CAST cycle ready SHALL drop and ballot_count SHALL increment, saturating at 255.
REQ-022 The FSM SHALL move from CAST to RELEASE, and SHALL stay in RELEASE until all buttons are sampled low, then go to IDLE; one ballot yields at most one vote.
REQ-023 Timer: a timer SHALL clear on entry to ARMED and count every cycle in ARMED and DEBOUNCE.
REQ-024 Timer expiry: when the timer reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, pulse timeout for one cycle, drop ready, and emit no vote.
REQ-025 If expiry and vote qualification occur on the same edge, the vote SHALL win.
REQ-026 end_voting=1 in any state except CAST SHALL go to CLOSED on that edge.
REQ-027 end_voting=1 during CAST SHALL let the pulse complete, then go to CLOSED.
REQ-028 CLOSED SHALL be sticky until reset: closed=1, ready=0, c1..c3=0, and ballot_en and buttons ignored.
REQ-029 c1, c2 and c3 SHALL never be high simultaneously.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, c1=c2=c3=0, ready=0, closed=0, timeout=0, ballot_count=0, and clear the timer and debounce counters.
REQ-031 Reset SHALL take effect mid-operation (ARMED, DEBOUNCE or CAST), abort any pending vote, and emit no pulse after release.
REQ-032 After rst_n deasserts, the first edge SHALL be processed normally from IDLE.

Verification
REQ-033 Bench: ballot_en pulse, btn2 held 4 cycles -> ready=1 one cycle after ballot_en; c2 single-cycle pulse at E0+4; ballot_count=1; ready=0.
REQ-034 Bench: btn1 held 3 cycles, released, then btn3 held 4 cycles -> no c1; c3 pulses once; ballot_count=1.
REQ-035 Bench: btn1+btn3 held together 10 cycles, then btn1 alone held 4 cycles -> no pulse during the overlap; one c1 pulse; continued holding gives no further votes until release and a new ballot_en.
REQ-036 Bench: ballot_en, no buttons for 255 cycles -> timeout one-cycle pulse, ready=0, ballot_count unchanged; btn2 pressed afterward gives no vote.
REQ-037 Bench: 8 ballots voting 1,2,3,3,1,1,3,1 -> ballot_count=8, with 4 c1, 1 c2 and 3 c3 pulses.
REQ-038 Bench: end_voting asserted, then ballot_en and btn1 pressed -> closed=1, and no c1/c2/c3 activity.
REQ-039 Bench: rst_n pulsed low during DEBOUNCE -> all outputs 0, and no vote pulse after release.
